mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO pair.
- HI/LO values return toward the register file write port through the MFHI/MFLO path.
- Shift-add multiply and restoring divide at one bit per cycle; start/busy/done handshake with the control unit.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits; iteration count = XLEN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous reset, active-low.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  XLEN  rs value / multiplicand / dividend.
- operand_b  input  XLEN  rt value / multiplier / divisor.
- mthi  input  1  write wdata to HI (MTHI).
- mtlo  input  1  write wdata to LO (MTLO).
- wdata  input  XLEN  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  output  1  qualifies done; divisor was zero.
- hi  output  XLEN  architectural HI.
- lo  output  XLEN  architectural LO.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; internal accumulators cleared.
- Reset asserted mid-operation aborts the operation; no partial result reaches hi/lo.
- States:
  - IDLE: start=1 at edge N latches operands and op, takes absolute values for signed ops, records sign flags, clears the iteration counter, and moves to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: XLEN cycles; each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator half, then shift the 2*XLEN accumulator right by 1 (carry kept).
  - DIV: XLEN cycles; shift {rem,quot} left, trial-subtract the divisor, keep the result and set quotient bit if it is non-negative, otherwise restore.
  - FIX: applies sign correction and writes hi/lo, pulses done, and returns to IDLE.
- Sign correction:
  - MULT: negate the 2*XLEN product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops have no correction.
- Results: multiply gives hi=product[2*XLEN-1:XLEN], lo=product[XLEN-1:0]; divide gives lo=quotient, hi=remainder.
- Latency:
  - start sampled at edge N; busy=1 from edge N through edge N+XLEN.
  - At edge N+XLEN+1: hi/lo updated, done=1, busy=0.
  - done falls at the next edge. For XLEN=32, result is visible 33 edges after start.
- Divide by zero:
  - Same latency, no trap.
  - hi=operand_a (as latched), lo=all ones, div_by_zero=1 during the done cycle only.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag.
- hi/lo hold their previous values throughout MUL/DIV; only FIX, mthi or mtlo change them.
- start while busy: ignored, no queuing.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins and the moves are dropped.
- mthi and mtlo together: both registers take wdata.
- mthi/mtlo take effect at the next edge, are visible the following cycle, and do not assert done.
- A new start is accepted in the cycle done is high (state is IDLE then); back-to-back operations are therefore XLEN+2 cycles apart.
- Operands are sampled only at the start edge; later changes on operand_a/operand_b have no effect.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x00001234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1 for one cycle with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 5×6, then pulse start (DIVU 9/3) and mthi (wdata=0xAAAA5555) at cycle 10 -> both ignored; hi=0, lo=30 at completion. Then mtlo with wdata=0x12345678 -> lo=0x12345678 next cycle, no done.
- Start DIVU 100/7, drive reset low at cycle 12 -> busy=0, done=0, hi=lo=0 immediately (asynchronous). Release reset, then DIVU 100/7 -> lo=14, hi=2.
- Start in the done cycle of a prior MULTU 2×3 -> first result hi=0, lo=6. Second op MULTU 4×4 -> lo=16 exactly 34 cycles after the first done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide retire one bit per cycle; a final
// FIX cycle applies sign correction and commits the result to hi/lo.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, next_state;

  // Iteration datapath: acc holds {upper,lower} product halves for multiply
  // and {remainder,quotient} for divide. opnd is the multiplicand or divisor.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_raw;
  logic [CNT_W-1:0]  count;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              dbz_pend;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;
  logic [2*XLEN-1:0] product;

  // Absolute value of a two's-complement operand when the op is signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic is_signed);
    logic signed [XLEN-1:0] sv;
    sv = v;
    if (is_signed && (sv < 0)) return -v;
    return v;
  endfunction

  // Conditional two's-complement negation of a single-width value.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                             input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negation of the double-width product.
  function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  // One multiply step: add the multiplicand on LSB, shift right keeping carry.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    if (acc[0]) mul_step = {mul_sum, acc[XLEN-1:1]};
    else        mul_step = {1'b0, acc[2*XLEN-1:1]};
  end

  // One restoring divide step: shift {rem,quot} left, trial-subtract divisor.
  always_comb begin
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_ge    = (div_trial >= {1'b0, opnd});
    div_diff  = div_trial[XLEN-1:0] - opnd;
    if (div_ge) div_step = {div_diff, acc[XLEN-2:0], 1'b1};
    else        div_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Final sign correction and result selection committed during FIX.
  always_comb begin
    product = neg_if2(acc, neg_q);
    fix_hi  = product[2*XLEN-1:XLEN];
    fix_lo  = product[XLEN-1:0];
    if (is_div) begin
      if (dbz_pend) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_if(acc[2*XLEN-1:XLEN], neg_r);
        fix_lo = neg_if(acc[XLEN-1:0], neg_q);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; busy covers every non-IDLE state including FIX.
  always_comb begin
    next_state = state;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) next_state = op[1] ? S_DIV : S_MUL;
      S_MUL:   if (count == LAST_ITER) next_state = S_FIX;
      S_DIV:   if (count == LAST_ITER) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture, iteration, result commit and HI/LO moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_raw    <= operand_a;
            is_div   <= op[1];
            count    <= '0;
            neg_q    <= ~op[0] & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
            neg_r    <= ~op[0] & operand_a[XLEN-1];
            dbz_pend <= op[1] & (operand_b == '0);
            if (op[1]) begin
              opnd <= magnitude(operand_b, ~op[0]);
              acc  <= {{XLEN{1'b0}}, magnitude(operand_a, ~op[0])};
            end else begin
              opnd <= magnitude(operand_a, ~op[0]);
              acc  <= {{XLEN{1'b0}}, magnitude(operand_b, ~op[0])};
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_MUL: begin
          acc   <= mul_step;
          count <= count + 1'b1;
        end
        S_DIV: begin
          acc   <= div_step;
          count <= count + 1'b1;
        end
        S_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dbz_pend;
        end
        default: ;
      endcase
    end
  end

endmodule
